// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: round-robin arbiter that shares one burst read port to memory
// between an I-cache and a D-cache requester.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   from_icache_rd_req_valid/addr : I-cache burst request in
//   to_icache_rd_req_ready        : I-cache request granted this cycle
//   to_icache_rd_rsp_valid/data/last, from_icache_rd_rsp_ready : I-cache response beats
//   from_dcache_* / to_dcache_*   : same set of signals for the D-cache
//   to_mem_rd_req_valid/addr, from_mem_rd_req_ready : request toward memory
//   from_mem_rd_rsp_valid/data/last, to_mem_rd_rsp_ready : response beats from memory
module mem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  from_icache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_icache_rd_req_addr,
  output logic                  to_icache_rd_req_ready,
  output logic                  to_icache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_icache_rd_rsp_data,
  output logic                  to_icache_rd_rsp_last,
  input  logic                  from_icache_rd_rsp_ready,
  input  logic                  from_dcache_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] from_dcache_rd_req_addr,
  output logic                  to_dcache_rd_req_ready,
  output logic                  to_dcache_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] to_dcache_rd_rsp_data,
  output logic                  to_dcache_rd_rsp_last,
  input  logic                  from_dcache_rd_rsp_ready,
  output logic                  to_mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
  input  logic                  from_mem_rd_req_ready,
  input  logic                  from_mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
  input  logic                  from_mem_rd_rsp_last,
  output logic                  to_mem_rd_rsp_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_MEM_REQ = 3'b010,
    S_RECV    = 3'b100
  } state_t;

  // Requester identity used for both owner and last-grant tracking.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  w_next_last_grant;
  logic                  r_owner;
  logic                  w_next_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_grant_d;
  logic                  w_owner_rsp_ready;

  // D-cache wins when alone, or on a tie when the I-cache was granted last.
  assign w_grant_d = from_dcache_rd_req_valid &
                     (~from_icache_rd_req_valid | (r_last_grant == OWNER_I));

  assign w_owner_rsp_ready = (r_owner == OWNER_D) ? from_dcache_rd_rsp_ready
                                                  : from_icache_rd_rsp_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= OWNER_D;
      r_owner      <= OWNER_I;
      r_addr       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
      r_owner      <= w_next_owner;
      r_addr       <= w_next_addr;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state           = r_state;
    w_next_last_grant      = r_last_grant;
    w_next_owner           = r_owner;
    w_next_addr            = r_addr;
    to_icache_rd_req_ready = 1'b0;
    to_dcache_rd_req_ready = 1'b0;
    to_icache_rd_rsp_valid = 1'b0;
    to_dcache_rd_rsp_valid = 1'b0;
    to_icache_rd_rsp_last  = 1'b0;
    to_dcache_rd_rsp_last  = 1'b0;
    to_icache_rd_rsp_data  = '0;
    to_dcache_rd_rsp_data  = '0;
    to_mem_rd_req_valid    = 1'b0;
    to_mem_rd_req_addr     = r_addr;
    to_mem_rd_rsp_ready    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (from_icache_rd_req_valid || from_dcache_rd_req_valid) begin
          w_next_state      = S_MEM_REQ;
          w_next_owner      = w_grant_d;
          w_next_last_grant = w_grant_d;
          if (w_grant_d) begin
            w_next_addr            = from_dcache_rd_req_addr;
            to_dcache_rd_req_ready = 1'b1;
          end else begin
            w_next_addr            = from_icache_rd_req_addr;
            to_icache_rd_req_ready = 1'b1;
          end
        end
      end
      S_MEM_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) begin
          w_next_state = S_RECV;
        end
      end
      S_RECV: begin
        to_icache_rd_rsp_data = from_mem_rd_rsp_data;
        to_dcache_rd_rsp_data = from_mem_rd_rsp_data;
        to_mem_rd_rsp_ready   = w_owner_rsp_ready;
        if (r_owner == OWNER_D) begin
          to_dcache_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dcache_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_icache_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_icache_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last && w_owner_rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Reset blanks all handshakes immediately so an aborted burst leaks no beats.
    if (rst) begin
      to_icache_rd_req_ready = 1'b0;
      to_dcache_rd_req_ready = 1'b0;
      to_icache_rd_rsp_valid = 1'b0;
      to_dcache_rd_rsp_valid = 1'b0;
      to_icache_rd_rsp_last  = 1'b0;
      to_dcache_rd_rsp_last  = 1'b0;
      to_icache_rd_rsp_data  = '0;
      to_dcache_rd_rsp_data  = '0;
      to_mem_rd_req_valid    = 1'b0;
      to_mem_rd_rsp_ready    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Testbench for mem_rd_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbiter's rules.
module tb_mem_rd_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_v, d_v, i_r, d_r;
  logic [AW-1:0] i_a, d_a;
  logic          m_qr, m_v, m_l;
  logic [DW-1:0] m_d;

  logic          to_icache_rd_req_ready, to_icache_rd_rsp_valid, to_icache_rd_rsp_last;
  logic [DW-1:0] to_icache_rd_rsp_data;
  logic          to_dcache_rd_req_ready, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_last;
  logic [DW-1:0] to_dcache_rd_rsp_data;
  logic          to_mem_rd_req_valid, to_mem_rd_rsp_ready;
  logic [AW-1:0] to_mem_rd_req_addr;

  mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .from_icache_rd_req_valid (i_v),
    .from_icache_rd_req_addr  (i_a),
    .to_icache_rd_req_ready   (to_icache_rd_req_ready),
    .to_icache_rd_rsp_valid   (to_icache_rd_rsp_valid),
    .to_icache_rd_rsp_data    (to_icache_rd_rsp_data),
    .to_icache_rd_rsp_last    (to_icache_rd_rsp_last),
    .from_icache_rd_rsp_ready (i_r),
    .from_dcache_rd_req_valid (d_v),
    .from_dcache_rd_req_addr  (d_a),
    .to_dcache_rd_req_ready   (to_dcache_rd_req_ready),
    .to_dcache_rd_rsp_valid   (to_dcache_rd_rsp_valid),
    .to_dcache_rd_rsp_data    (to_dcache_rd_rsp_data),
    .to_dcache_rd_rsp_last    (to_dcache_rd_rsp_last),
    .from_dcache_rd_rsp_ready (d_r),
    .to_mem_rd_req_valid      (to_mem_rd_req_valid),
    .to_mem_rd_req_addr       (to_mem_rd_req_addr),
    .from_mem_rd_req_ready    (m_qr),
    .from_mem_rd_rsp_valid    (m_v),
    .from_mem_rd_rsp_data     (m_d),
    .from_mem_rd_rsp_last     (m_l),
    .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: who holds the memory port (-1 none, 0 I, 1 D),
  // whether its request has been accepted by memory, and round-robin history.
  int            m_owner;
  bit            m_sent;
  int            m_last;
  logic [AW-1:0] m_addr;

  logic [DW-1:0] obs_i[$];
  logic [DW-1:0] obs_d[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (i_v && d_v) return 1 - m_last;
    return i_v ? 0 : 1;
  endfunction

  task automatic check_outputs();
    logic e_irdy, e_drdy, e_mv, e_irv, e_drv, e_il, e_dl, e_mrr;
    {e_irdy, e_drdy, e_mv, e_irv, e_drv, e_il, e_dl, e_mrr} = '0;
    if (!rst) begin
      if (m_owner < 0) begin
        if (i_v || d_v) begin
          if (pick() == 0) e_irdy = 1'b1;
          else             e_drdy = 1'b1;
        end
      end else if (!m_sent) begin
        e_mv = 1'b1;
      end else begin
        if (m_owner == 0) begin
          e_irv = m_v; e_il = m_l; e_mrr = i_r;
        end else begin
          e_drv = m_v; e_dl = m_l; e_mrr = d_r;
        end
        chk("i_rsp_data", 64'(to_icache_rd_rsp_data), 64'(m_d));
        chk("d_rsp_data", 64'(to_dcache_rd_rsp_data), 64'(m_d));
      end
      chk("mem_req_addr", 64'(to_mem_rd_req_addr), 64'(m_addr));
    end
    chk("i_req_ready", 64'(to_icache_rd_req_ready), 64'(e_irdy));
    chk("d_req_ready", 64'(to_dcache_rd_req_ready), 64'(e_drdy));
    chk("mem_req_valid", 64'(to_mem_rd_req_valid), 64'(e_mv));
    chk("i_rsp_valid", 64'(to_icache_rd_rsp_valid), 64'(e_irv));
    chk("d_rsp_valid", 64'(to_dcache_rd_rsp_valid), 64'(e_drv));
    chk("i_rsp_last", 64'(to_icache_rd_rsp_last), 64'(e_il));
    chk("d_rsp_last", 64'(to_dcache_rd_rsp_last), 64'(e_dl));
    chk("mem_rsp_ready", 64'(to_mem_rd_rsp_ready), 64'(e_mrr));
  endtask

  task automatic update_model();
    int w;
    if (rst) begin
      m_owner = -1; m_sent = 1'b0; m_last = 1; m_addr = '0;
    end else if (m_owner < 0) begin
      if (i_v || d_v) begin
        w = pick();
        m_owner = w; m_last = w; m_sent = 1'b0;
        m_addr  = (w == 1) ? d_a : i_a;
      end
    end else if (!m_sent) begin
      if (m_qr) m_sent = 1'b1;
    end else if (m_v && m_l && ((m_owner == 0) ? i_r : d_r)) begin
      m_owner = -1;
    end
  endtask

  // One clock: inputs already driven; settle, check, record, advance model.
  task automatic tick();
    #1;
    check_outputs();
    if (to_icache_rd_rsp_valid && i_r) obs_i.push_back(to_icache_rd_rsp_data);
    if (to_dcache_rd_rsp_valid && d_r) obs_d.push_back(to_dcache_rd_rsp_data);
    update_model();
    @(posedge clk);
    #1;
  endtask

  // Drive an n-beat burst; owner holds ready low for stall_len cycles on stall_beat.
  task automatic burst(input int who, input int n, input logic [DW-1:0] base,
                       input int stall_beat, input int stall_len);
    for (int b = 0; b < n; b++) begin
      for (int s = 0; s <= ((b == stall_beat) ? stall_len : 0); s++) begin
        m_v = 1'b1;
        m_d = base + DW'(b);
        m_l = (b == n - 1);
        i_r = 1'b1;
        d_r = 1'b1;
        if (b == stall_beat && s < stall_len) begin
          if (who == 0) i_r = 1'b0;
          else          d_r = 1'b0;
        end
        tick();
      end
    end
    m_v = 1'b0; m_l = 1'b0; m_d = '0; i_r = 1'b1; d_r = 1'b1;
  endtask

  task automatic chk_q(input string tag, input logic [DW-1:0] q[$],
                       input logic [DW-1:0] base, input int n);
    chk({tag, "_count"}, 64'(q.size()), 64'(n));
    for (int k = 0; k < q.size() && k < n; k++) begin
      chk({tag, "_beat"}, 64'(q[k]), 64'(base + DW'(k)));
    end
  endtask

  initial begin
    m_owner = -1; m_sent = 1'b0; m_last = 1; m_addr = '0;
    rst = 1'b1;
    i_v = 1'b0; d_v = 1'b0; i_a = '0; d_a = '0; i_r = 1'b1; d_r = 1'b1;
    m_qr = 1'b0; m_v = 1'b0; m_l = 1'b0; m_d = '0;
    @(posedge clk); #1;

    // Requests during reset must not be granted.
    i_v = 1'b1; d_v = 1'b1;
    tick(); tick();
    rst = 1'b0; i_v = 1'b0; d_v = 1'b0;
    tick();

    // Single I-cache request and 8-beat burst.
    i_v = 1'b1; i_a = 32'h0000_1000;
    tick();
    i_v = 1'b0; m_qr = 1'b1;
    tick();
    m_qr = 1'b0;
    obs_i.delete(); obs_d.delete();
    burst(0, 8, 32'h0, -1, 0);
    tick();
    chk_q("icache_burst", obs_i, 32'h0, 8);
    chk("dcache_no_beats", 64'(obs_d.size()), 64'd0);

    // Round-robin: tie -> I, then pending D, then tie -> I again.
    rst = 1'b1; tick(); rst = 1'b0;
    i_v = 1'b1; d_v = 1'b1; i_a = 32'h0000_2000; d_a = 32'h0000_3000;
    tick();
    i_v = 1'b0; m_qr = 1'b1;
    tick();
    burst(0, 8, 32'h100, -1, 0);
    tick();
    d_v = 1'b0;
    tick();
    burst(1, 4, 32'h200, -1, 0);
    i_v = 1'b1; d_v = 1'b1; i_a = 32'h0000_2020; d_a = 32'h0000_3020;
    tick();
    i_v = 1'b0; d_v = 1'b0;
    tick();
    burst(0, 2, 32'h300, -1, 0);

    // Memory request backpressure, then D-cache response stall on beat 3.
    d_v = 1'b1; d_a = 32'h0000_4000;
    tick();
    d_v = 1'b0; m_qr = 1'b0;
    repeat (5) tick();
    m_qr = 1'b1;
    tick();
    obs_i.delete(); obs_d.delete();
    burst(1, 8, 32'hB0, 3, 2);
    tick();
    chk_q("dcache_stall_burst", obs_d, 32'hB0, 8);

    // Reset mid-burst aborts; D-cache is then served normally.
    i_v = 1'b1; i_a = 32'h0000_5000;
    tick();
    i_v = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      m_v = 1'b1; m_d = 32'hC0 + DW'(b); m_l = 1'b0;
      tick();
    end
    m_d = 32'hC4; rst = 1'b1;
    tick();
    rst = 1'b0; m_v = 1'b0; m_d = '0;
    tick();
    d_v = 1'b1; d_a = 32'h0000_6000;
    tick();
    d_v = 1'b0;
    tick();
    burst(1, 2, 32'hD0, -1, 0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 79) == 0);
      i_v  = ($urandom_range(0, 2) != 0);
      d_v  = ($urandom_range(0, 2) != 0);
      i_a  = $urandom() & 32'hFFFF_FFE0;
      d_a  = $urandom() & 32'hFFFF_FFE0;
      i_r  = ($urandom_range(0, 3) != 0);
      d_r  = ($urandom_range(0, 3) != 0);
      m_qr = ($urandom_range(0, 1) != 0);
      m_v  = ($urandom_range(0, 3) != 0);
      m_l  = m_v && ($urandom_range(0, 3) == 0);
      m_d  = $urandom();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 ADDR_WIDTH, 32, width of all read-request addresses.
REQ-002 DATA_WIDTH, 32, width of one response data beat.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 from_icache_rd_req_valid  input  1  I-cache read request valid.
REQ-006 from_icache_rd_req_addr  input  ADDR_WIDTH  I-cache burst address, 32-byte aligned.
REQ-007 to_icache_rd_req_ready  output  1  I-cache request accepted this cycle.
REQ-008 to_icache_rd_rsp_valid  output  1  response beat valid toward I-cache.
REQ-009 to_icache_rd_rsp_data  output  DATA_WIDTH  response beat data toward I-cache.
REQ-010 to_icache_rd_rsp_last  output  1  last beat of the I-cache burst.
REQ-011 from_icache_rd_rsp_ready  input  1  I-cache accepts the current beat.
REQ-012 from_dcache_rd_req_valid, from_dcache_rd_req_addr, to_dcache_rd_req_ready, to_dcache_rd_rsp_valid, to_dcache_rd_rsp_data, to_dcache_rd_rsp_last, from_dcache_rd_rsp_ready: same directions, widths and meanings as REQ-005..011, for the D-cache.
REQ-013 to_mem_rd_req_valid  output  1  read request valid toward memory.
REQ-014 to_mem_rd_req_addr  output  ADDR_WIDTH  latched address of the granted requester.
REQ-015 from_mem_rd_req_ready  input  1  memory accepts the request.
REQ-016 from_mem_rd_rsp_valid  input  1  memory beat valid.
REQ-017 from_mem_rd_rsp_data  input  DATA_WIDTH  memory beat data.
REQ-018 from_mem_rd_rsp_last  input  1  last memory beat of the burst.
REQ-019 to_mem_rd_rsp_ready  output  1  arbiter (granted requester) accepts the beat.

Function
REQ-020 FSM states SHALL be IDLE, MEM_REQ and RECV, one-hot encoded.
REQ-021 IDLE: if either requester's valid is high, grant one, drive its req_ready=1 for that cycle only, latch its address and the grant owner, then go to MEM_REQ; otherwise stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: a single requester wins alone; when both are valid, the requester not granted last wins.
REQ-023 last_grant SHALL update only on an accepted grant.
REQ-024 The non-granted requester's req_ready SHALL stay 0, and its request SHALL remain pending.
REQ-025 MEM_REQ: to_mem_rd_req_valid=1 with the latched address, held stable until from_mem_rd_req_ready=1, then go to RECV.
REQ-026 RECV: owner's rsp_valid = from_mem_rd_rsp_valid; rsp_data = mem data; rsp_last = mem last; to_mem_rd_rsp_ready = owner's rsp_ready.
REQ-027 RECV: the non-owner's rsp_valid and rsp_last SHALL be 0, and both rsp_data outputs SHALL carry mem data.
REQ-028 RECV SHALL exit to IDLE on the cycle where mem rsp_valid, mem rsp_last and owner rsp_ready are all 1.
REQ-029 A new grant SHALL be possible on the cycle after the RECV exit.
REQ-030 Latency: grant at cycle N, to_mem_rd_req_valid=1 at cycle N+1; no combinational path from requester valid to to_mem_rd_req_valid.
REQ-031 A beat with owner rsp_ready=0 SHALL NOT be consumed; the arbiter stalls with memory and loses no data.
REQ-032 Requester valid changes outside IDLE SHALL be ignored.
REQ-033 Outside RECV, all rsp_valid and rsp_last outputs and to_mem_rd_rsp_ready SHALL be 0.
REQ-034 Outside MEM_REQ, to_mem_rd_req_valid SHALL be 0.

Reset
REQ-035 rst=1 SHALL force IDLE, set last_grant=D-cache (so the I-cache wins the first tie), and clear the latched owner and address to 0.
REQ-036 During reset, all valid, ready and last outputs SHALL be 0.
REQ-037 Reset asserted in MEM_REQ or RECV SHALL abort the transaction with no further beats forwarded to either requester.

Verification
REQ-038 I-cache alone requests 0x0000_1000 -> to_icache_rd_req_ready=1 for 1 cycle; next cycle to_mem_rd_req_valid=1 with addr 0x0000_1000.
REQ-039 I-cache burst: 8 beats 0..7, last on beat 7 -> all reach the I-cache only, dcache rsp_valid stays 0, then IDLE.
REQ-040 Both request in the same cycle after reset -> I-cache granted; after its burst the D-cache (still valid) is granted; a further simultaneous request grants the I-cache.
REQ-041 from_mem_rd_req_ready held 0 for 5 cycles -> req_valid and addr held stable for 5 cycles; transition to RECV occurs on the ready cycle.
REQ-042 D-cache rsp_ready=0 on beat 3 for 2 cycles -> to_mem_rd_rsp_ready=0 for those cycles; beat 3 is delivered once with data intact.
REQ-043 rst pulse during beat 4 of an I-cache burst -> next cycle IDLE with all outputs 0; a following D-cache request is granted normally.
